// File: rtl/serial_alu_wide.sv
// serial_alu_wide: digit-serial ALU with WIDTH-bit operands and a DIGIT-bit datapath.
// The operands are taken over a valid/ready input channel. The result is computed
// LSB first over N = WIDTH/DIGIT cycles. It is returned with a carry flag and an
// illegal-code flag over a valid/ready output channel that honours backpressure.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for operands, din_rdy = 1
//   BUSY  | processing one digit per edge, counter 0..N-1
//   DONE  | result held on dout_*, din_rdy follows dout_rdy

module serial_alu_wide #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_di1,
    input  logic [WIDTH-1:0] din_di2,
    input  logic [2:0]       din_fun,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic [WIDTH-1:0] dout_dat,
    output logic             dout_cy,
    output logic             dout_err,
    output logic             dout_vld,
    input  logic             dout_rdy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] FUN_ADD = 3'd0;
    localparam logic [2:0] FUN_AND = 3'd1;
    localparam logic [2:0] FUN_OR  = 3'd2;
    localparam logic [2:0] FUN_XOR = 3'd3;
    localparam logic [2:0] FUN_SUB = 3'd4;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_alu_wide: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       fun_q;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             last_digit;
    logic             fun_legal;

    logic [DIGIT-1:0] a_d;
    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] dig;
    logic             cy_next;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0] res_next;

    assign accept     = din_vld && din_rdy;
    assign last_digit = (cnt_q == CW'(N - 1));
    assign fun_legal  = (fun_q <= FUN_SUB);

    // One digit of the ALU: carry ripples inside the digit, and the result is shifted in from the top.
    always_comb begin
        a_d     = a_q[DIGIT-1:0];
        b_eff   = (fun_q == FUN_SUB) ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
        sum     = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cy_q};
        dig     = '0;
        cy_next = 1'b0;
        case (fun_q)
            FUN_ADD, FUN_SUB: begin
                dig     = sum[DIGIT-1:0];
                cy_next = sum[DIGIT];
            end
            FUN_AND: dig = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
            FUN_OR:  dig = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
            FUN_XOR: dig = a_q[DIGIT-1:0] ^ b_q[DIGIT-1:0];
            default: begin
                dig     = '0;
                cy_next = 1'b0;
            end
        endcase
        res_cat  = {dig, res_q};
        res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Both ready and valid are held low while reset is asserted.
    always_comb begin
        state_next = state;
        din_rdy    = 1'b0;
        dout_vld   = 1'b0;
        case (state)
            IDLE: begin
                din_rdy = 1'b1;
                if (din_vld) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                dout_vld = 1'b1;
                din_rdy  = dout_rdy;
                if (dout_rdy) begin
                    state_next = din_vld ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            din_rdy  = 1'b0;
            dout_vld = 1'b0;
        end
    end

    // Operand capture, digit stepping, and result registration on the final digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            fun_q    <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            dout_dat <= '0;
            dout_cy  <= 1'b0;
            dout_err <= 1'b0;
        end else if (accept) begin
            a_q   <= din_di1;
            b_q   <= din_di2;
            fun_q <= din_fun;
            cy_q  <= (din_fun == FUN_SUB);
            res_q <= '0;
            cnt_q <= '0;
        end else if (state == BUSY) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            res_q <= res_next;
            cy_q  <= cy_next;
            cnt_q <= cnt_q + CW'(1);
            if (last_digit) begin
                dout_dat <= fun_legal ? res_next : '0;
                dout_cy  <= fun_legal ? cy_next : 1'b0;
                dout_err <= !fun_legal;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_wide.sv
// tb_serial_alu_wide: directed vector tables, handshake corner cases, and a
// randomized stream for two configurations (8/1 and 16/4) of serial_alu_wide.

module tb_serial_alu_wide;

    logic        clock = 1'b0;
    logic        reset;

    logic [7:0]  di1_8, di2_8, dat8;
    logic [2:0]  fun8;
    logic        vld8, rdy8, drdy8, cy8, err8, ovld8;

    logic [15:0] di1_16, di2_16, dat16;
    logic [2:0]  fun16;
    logic        vld16, rdy16, drdy16, cy16, err16, ovld16;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] dat;
        logic        cy;
        logic        err;
    } vec_t;

    vec_t v8[7];
    vec_t v16[5];

    serial_alu_wide #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clock(clock), .reset(reset),
        .din_di1(di1_8), .din_di2(di2_8), .din_fun(fun8),
        .din_vld(vld8), .din_rdy(drdy8),
        .dout_dat(dat8), .dout_cy(cy8), .dout_err(err8),
        .dout_vld(ovld8), .dout_rdy(rdy8)
    );

    serial_alu_wide #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clock(clock), .reset(reset),
        .din_di1(di1_16), .din_di2(di2_16), .din_fun(fun16),
        .din_vld(vld16), .din_rdy(drdy16),
        .dout_dat(dat16), .dout_cy(cy16), .dout_err(err16),
        .dout_vld(ovld16), .dout_rdy(rdy16)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: {err, cy, dat} from plain arithmetic on w-bit operands.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic [2:0] f);
        longint unsigned mask;
        longint unsigned s;
        logic [31:0] dat;
        logic        cy;
        logic        err;
        mask = (64'd1 << w) - 64'd1;
        dat = '0;
        cy  = 1'b0;
        err = 1'b0;
        case (f)
            3'd0: begin
                s   = longint'(a) + longint'(b);
                dat = 32'(s & mask);
                cy  = ((s >> w) & 64'd1) != 0;
            end
            3'd1: dat = a & b;
            3'd2: dat = a | b;
            3'd3: dat = a ^ b;
            3'd4: begin
                s   = longint'(a) - longint'(b);
                dat = 32'(s & mask);
                cy  = (a >= b);
            end
            default: err = 1'b1;
        endcase
        return {err, cy, dat};
    endfunction

    task automatic run8(input string name, input logic [2:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] edat,
                        input logic ecy, input logic eerr);
        int lat;
        di1_8 = a; di2_8 = b; fun8 = f; vld8 = 1'b1;
        #1;
        check({name, " rdy"}, 32'(drdy8), 32'd1);
        @(negedge clock);
        vld8 = 1'b0;
        di1_8 = 8'($urandom); di2_8 = 8'($urandom); fun8 = 3'($urandom);
        lat = 0;
        while (!ovld8 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd8);
        check({name, " dat"}, 32'(dat8), 32'(edat));
        check({name, " cy"}, 32'(cy8), 32'(ecy));
        check({name, " err"}, 32'(err8), 32'(eerr));
        rdy8 = 1'b1;
        @(negedge clock);
        rdy8 = 1'b0;
        check({name, " vld after xfer"}, 32'(ovld8), 32'd0);
    endtask

    task automatic run16(input string name, input logic [2:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] edat,
                         input logic ecy, input logic eerr);
        int lat;
        di1_16 = a; di2_16 = b; fun16 = f; vld16 = 1'b1;
        #1;
        check({name, " rdy"}, 32'(drdy16), 32'd1);
        @(negedge clock);
        vld16 = 1'b0;
        di1_16 = 16'($urandom); di2_16 = 16'($urandom); fun16 = 3'($urandom);
        lat = 0;
        while (!ovld16 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " dat"}, 32'(dat16), 32'(edat));
        check({name, " cy"}, 32'(cy16), 32'(ecy));
        check({name, " err"}, 32'(err16), 32'(eerr));
        rdy16 = 1'b1;
        @(negedge clock);
        rdy16 = 1'b0;
        check({name, " vld after xfer"}, 32'(ovld16), 32'd0);
    endtask

    initial begin
        logic [33:0] r;
        logic [33:0] q[$];
        logic [7:0]  a, b;
        logic [2:0]  f;
        int          acc;
        int          iter;
        int          lat;

        v8[0] = '{"add_c8_64", 3'd0, 16'hC8, 16'h64, 16'h2C, 1'b1, 1'b0};
        v8[1] = '{"sub_10_20", 3'd4, 16'h10, 16'h20, 16'hF0, 1'b0, 1'b0};
        v8[2] = '{"sub_20_20", 3'd4, 16'h20, 16'h20, 16'h00, 1'b1, 1'b0};
        v8[3] = '{"ill6_ff_ff", 3'd6, 16'hFF, 16'hFF, 16'h00, 1'b0, 1'b1};
        v8[4] = '{"add_ff_01", 3'd0, 16'hFF, 16'h01, 16'h00, 1'b1, 1'b0};
        v8[5] = '{"xor_a5_ff", 3'd3, 16'hA5, 16'hFF, 16'h5A, 1'b0, 1'b0};
        v8[6] = '{"sub_00_00", 3'd4, 16'h00, 16'h00, 16'h00, 1'b1, 1'b0};

        v16[0] = '{"and16", 3'd1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
        v16[1] = '{"or16",  3'd2, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0};
        v16[2] = '{"xor16", 3'd3, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0};
        v16[3] = '{"add16_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        v16[4] = '{"sub16_borrow", 3'd4, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0};

        reset = 1'b1;
        di1_8 = '0; di2_8 = '0; fun8 = '0; vld8 = 1'b0; rdy8 = 1'b0;
        di1_16 = '0; di2_16 = '0; fun16 = '0; vld16 = 1'b0; rdy16 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset rdy8", 32'(drdy8), 32'd0);
        check("reset vld8", 32'(ovld8), 32'd0);
        check("reset dat8", 32'(dat8), 32'd0);
        check("reset cy_err8", 32'({cy8, err8}), 32'd0);
        check("reset vld16", 32'(ovld16), 32'd0);
        reset = 1'b0;
        #1;
        check("post-reset rdy8", 32'(drdy8), 32'd1);
        @(negedge clock);

        for (int i = 0; i < 7; i++)
            run8(v8[i].name, v8[i].f, v8[i].a[7:0], v8[i].b[7:0], v8[i].dat[7:0],
                 v8[i].cy, v8[i].err);
        for (int i = 0; i < 5; i++)
            run16(v16[i].name, v16[i].f, v16[i].a, v16[i].b, v16[i].dat,
                  v16[i].cy, v16[i].err);

        // Backpressure: result held while dout_rdy is low, then transfer plus accept on one edge.
        di1_8 = 8'h01; di2_8 = 8'h02; fun8 = 3'd0; vld8 = 1'b1;
        @(negedge clock);
        vld8 = 1'b0;
        lat = 0;
        while (!ovld8 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("bp first latency", 32'(lat), 32'd8);
        di1_8 = 8'h30; di2_8 = 8'h05; fun8 = 3'd4; vld8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp hold dat", 32'(dat8), 32'h03);
            check("bp hold vld", 32'(ovld8), 32'd1);
            check("bp hold rdy", 32'(drdy8), 32'd0);
            @(negedge clock);
        end
        rdy8 = 1'b1;
        #1;
        check("bp release rdy", 32'(drdy8), 32'd1);
        @(negedge clock);
        rdy8 = 1'b0; vld8 = 1'b0;
        check("bp vld after xfer", 32'(ovld8), 32'd0);
        lat = 0;
        while (!ovld8 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("bp second latency", 32'(lat), 32'd8);
        check("bp second dat", 32'(dat8), 32'h2B);
        check("bp second cy", 32'(cy8), 32'd1);
        rdy8 = 1'b1;
        @(negedge clock);
        rdy8 = 1'b0;

        // Reset three cycles into BUSY aborts the operation.
        di1_8 = 8'h11; di2_8 = 8'h22; fun8 = 3'd0; vld8 = 1'b1;
        @(negedge clock);
        vld8 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort vld", 32'(ovld8), 32'd0);
        check("abort rdy", 32'(drdy8), 32'd1);
        check("abort outputs", 32'({dat8, cy8, err8}), 32'd0);
        rdy8 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("abort no stale vld", 32'(ovld8), 32'd0);
        end
        rdy8 = 1'b0;

        // Random stream on the 8-bit instance with a queue-based scoreboard.
        acc = 0;
        iter = 0;
        while ((acc < 1000 || q.size() != 0) && iter < 40000) begin
            a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            f = 3'($urandom_range(0, 7));
            di1_8 = a; di2_8 = b; fun8 = f;
            vld8 = (acc < 1000) && ($urandom_range(0, 3) != 0);
            rdy8 = (acc >= 1000) || ($urandom_range(0, 3) != 0);
            #1;
            if (ovld8 && rdy8) begin
                if (q.size() == 0) begin
                    check("rand spurious vld", 32'(ovld8), 32'd0);
                end else begin
                    r = q.pop_front();
                    check("rand dat", 32'(dat8), 32'(r[7:0]));
                    check("rand cy", 32'(cy8), 32'(r[32]));
                    check("rand err", 32'(err8), 32'(r[33]));
                end
            end
            if (vld8 && drdy8) begin
                q.push_back(ref_op(8, 32'(a), 32'(b), f));
                acc++;
            end
            @(negedge clock);
            iter++;
        end
        vld8 = 1'b0; rdy8 = 1'b0;
        check("rand ops accepted", 32'(acc), 32'd1000);
        check("rand queue drained", 32'(q.size()), 32'd0);

        // A shorter random pass on the 16-bit, 4-bit-digit instance.
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a16, b16;
            a16 = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            b16 = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            f = 3'($urandom_range(0, 7));
            r = ref_op(16, 32'(a16), 32'(b16), f);
            run16("rand16", f, a16, b16, r[15:0], r[32], r[33]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_alu_wide.md
Name: serial_alu_wide

Overview:
Parametrised successor to the team's bit-serial ALU. Accepts two WIDTH-bit operands and a 3-bit function code over a valid/ready handshake. Computes the result DIGIT bits per cycle, LSB first, and returns it with a carry flag over a valid/ready output channel that supports backpressure. It sits between a command source and a result consumer in the same serial-datapath test harnesses, replacing the fixed 8-bit, 1-bit-per-cycle, no-backpressure version.

Parameters:
- WIDTH, 8: operand and result width in bits; must be at least 2.
- DIGIT, 1: bits processed per cycle.
  - WIDTH % DIGIT must be 0; elaboration fails otherwise.
  - N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clock   in   1      clock
- reset   in   1      synchronous, active-high reset
- din_di1 in   WIDTH  operand A
- din_di2 in   WIDTH  operand B
- din_fun in   3      function code
- din_vld in   1      input valid
- din_rdy out  1      input ready
- dout_dat out WIDTH  result
- dout_cy  out 1      carry / not-borrow flag
- dout_err out 1      illegal function code flag
- dout_vld out 1      output valid
- dout_rdy in  1      output ready

Behaviour:
- Reset:
  - Synchronous, active-high reset; clock is `clock`.
  - Reset forces state IDLE and clears dout_dat, dout_cy, dout_err and dout_vld to 0. din_rdy reads 0 during the reset cycle.
  - Reset asserted mid-operation aborts the operation and discards partial results. No output transfer occurs for the aborted operation.
- State machine:
  - States are IDLE, BUSY and DONE. A digit counter runs 0..N-1.
- IDLE:
  - din_rdy = 1.
  - On an edge with din_vld = 1, the block latches di1, di2 and fun, clears the carry register, clears the counter and moves to BUSY.
  - The carry register is preset to 1 when fun = 4 (SUB).
- BUSY:
  - din_rdy = 0 and dout_vld = 0.
  - Each edge processes the next DIGIT bits, LSB first, and increments the counter.
  - The edge that processes digit N-1 moves the block to DONE, with result, dout_cy and dout_err registered.
- Latency:
  - Accept at edge E0 gives dout_vld = 1 after edge EN (N cycles later).
  - With WIDTH = 8 and DIGIT = 1, that is 8 cycles.
- DONE:
  - dout_vld = 1. dout_dat, dout_cy and dout_err stay stable until transfer.
  - din_rdy = dout_rdy (combinational pass-through).
  - dout_vld=1, dout_rdy=1, din_vld=1 on the same edge: output transfers and the new operands are accepted; next state is BUSY (back-to-back, no idle cycle).
  - dout_vld=1, dout_rdy=1, din_vld=0: output transfers; next state is IDLE.
  - dout_rdy=0: the block holds in DONE indefinitely. din_vld is ignored.
- Function codes:
  - 0 ADD: A+B.
  - 1 AND, 2 OR, 3 XOR: bitwise.
  - 4 SUB: A + ~B + 1.
  - 5..7: illegal.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - dout_cy is the carry out of the MSB for ADD and SUB; for SUB it equals 1 when A >= B (no borrow).
  - dout_cy = 0 for logic ops.
  - Carry ripples within a digit and is registered between digits.
- Illegal codes: the same N-cycle latency applies; dout_dat = 0, dout_cy = 0, dout_err = 1. dout_err = 0 for legal codes.
- din_* are sampled only on the accept edge. Changes on din_* during BUSY or DONE have no effect.

Test Plan:
- WIDTH=8/DIGIT=1, ADD 0xC8+0x64 -> dout_vld exactly 8 cycles after accept; dat=0x2C, cy=1, err=0.
- WIDTH=8/DIGIT=1, SUB 0x10-0x20 -> dat=0xF0, cy=0. SUB 0x20-0x20 -> dat=0x00, cy=1.
- WIDTH=16/DIGIT=4, AND/OR/XOR of 0xF0F0 and 0x3C3C -> 0x3030, 0xFCFC and 0xCCCC respectively, each 4 cycles after accept, cy=0.
- Backpressure: hold dout_rdy=0 for 5 cycles with din_vld=1 -> dout_dat stable, din_rdy=0 throughout. Then raise dout_rdy -> output transfer and new accept on the same edge, next result N cycles later.
- Illegal fun=6 with A=0xFF, B=0xFF -> dat=0, cy=0, err=1 after N cycles. The following legal op -> err=0.
- Reset asserted 3 cycles into BUSY -> next cycle dout_vld=0, din_rdy=1, outputs 0, and no stale result ever appears. Then 1000 random ops (including zero operands and back-to-back accepts) checked against a reference model.
